multicycle_ctrl: RTL and testbench

- Parametrised multi-cycle RISC-V control unit.
- Drives the existing multi-cycle datapath control set: PC/IR write, address/ALU/result muxes, ALU operation and immediate format.
- Adds a variable-latency memory handshake with bounded wait, a fault/halt state for illegal opcodes and memory timeouts, and an optional full conditional-branch set.
- Sits between the instruction register fields/ALU flags and the datapath, replacing the fixed single-cycle-memory controller.

---
 rtl/multicycle_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RISC-V control unit with handshaked memory, timeout fault and halt.
// Define MULTICYCLE_CTRL_FULL_BRANCH_EN to accept bne/blt/bge in addition to beq.
module multicycle_ctrl #(
    parameter int TIMEOUT = 15,
    parameter bit MEM_HS  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] Flags,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Fault,
    output logic [3:0] State
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_HALT     = 4'd11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q;

    logic is_load, is_store, is_r, is_i, is_br, is_jal;
    logic mem_st, req, done, tmo;
    logic alu_ok, br_ok, br_take;
    logic [2:0] alu_op, imm;

    assign is_load  = (op == 7'b0000011);
    assign is_store = (op == 7'b0100011);
    assign is_r     = (op == 7'b0110011);
    assign is_i     = (op == 7'b0010011);
    assign is_br    = (op == 7'b1100011);
    assign is_jal   = (op == 7'b1101111);

    // run_q holds strobes off until the first edge after reset release
    assign mem_st = (state_q == S_FETCH) || (state_q == S_MEMREAD)
                 || (state_q == S_MEMWRITE);
    assign req    = run_q & mem_st;
    assign done   = req & (MEM_HS ? MemReady : 1'b1);
    assign tmo    = req & ~done & (cnt_q == CW'(TIMEOUT));

    always_comb begin
        alu_op = ALU_ADD;
        alu_ok = 1'b1;
        case (funct3)
            3'b000: alu_op = (state_q == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010: alu_op = ALU_SLT;
            3'b110: alu_op = ALU_OR;
            3'b111: alu_op = ALU_AND;
            default: alu_ok = 1'b0;
        endcase
    end

`ifdef MULTICYCLE_CTRL_FULL_BRANCH_EN
    always_comb begin
        br_ok   = 1'b1;
        br_take = 1'b0;
        case (funct3)
            3'b000: br_take = Flags[0];
            3'b001: br_take = ~Flags[0];
            3'b100: br_take = Flags[1];
            3'b101: br_take = ~Flags[1];
            default: br_ok = 1'b0;
        endcase
    end
`else
    logic unused_sign;
    assign unused_sign = Flags[1];
    assign br_ok       = (funct3 == 3'b000);
    assign br_take     = Flags[0];
`endif

    always_comb begin
        imm = 3'b000;
        unique case (1'b1)
            is_store: imm = 3'b001;
            is_br:    imm = 3'b010;
            is_jal:   imm = 3'b011;
            default:  imm = 3'b000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    if (tmo)       state_d = S_HALT;
                    else if (done) state_d = S_DECODE;
                end
                S_DECODE: begin
                    unique case (1'b1)
                        is_load | is_store: state_d = S_MEMADR;
                        is_r:               state_d = S_EXECR;
                        is_i:               state_d = S_EXECI;
                        is_br & br_ok:      state_d = S_BRANCH;
                        is_jal:             state_d = S_JAL;
                        default:            state_d = S_HALT;
                    endcase
                end
                S_MEMADR: state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD: begin
                    if (tmo)       state_d = S_HALT;
                    else if (done) state_d = S_MEMWB;
                end
                S_MEMWB: state_d = S_FETCH;
                S_MEMWRITE: begin
                    if (tmo)       state_d = S_HALT;
                    else if (done) state_d = S_FETCH;
                end
                S_EXECR, S_EXECI: state_d = alu_ok ? S_ALUWB : S_HALT;
                S_ALUWB:  state_d = S_FETCH;
                S_BRANCH: state_d = S_FETCH;
                S_JAL:    state_d = S_ALUWB;
                default:  state_d = S_HALT;
            endcase
        end
    end

    // counter restarts whenever the state changes
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)  cnt_d = '0;
        else if (req && !done)   cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = 3'b000;
        if (run_q && state_q != S_HALT) begin
            ImmSrc = imm;
            case (state_q)
                S_FETCH: begin
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = done;
                    PCWrite   = done;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD: AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR, S_EXECI: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                    ALUControl = alu_op;
                end
                S_ALUWB: RegWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = ALU_SUB;
                    PCWrite    = br_take;
                end
                S_JAL: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign MemReq = req;
    assign Fault  = (state_q == S_HALT);
    assign State  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Trace-based bench: each instruction expands into an expected per-cycle trace.
// Random ops, waits and flags are mixed with directed corner cases.
module tb_multicycle_ctrl;

    localparam int TO = 4;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXECR    = 4'd6;
    localparam logic [3:0] ST_EXECI    = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;
    localparam logic [3:0] ST_JAL      = 4'd10;
    localparam logic [3:0] ST_HALT     = 4'd11;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [1:0] Flags;
    logic       MemReady;
    logic       MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUControl;
    logic       Fault;
    logic [3:0] State;

    multicycle_ctrl #(.TIMEOUT(TO), .MEM_HS(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .Flags(Flags), .MemReady(MemReady),
        .MemReq(MemReq), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Fault(Fault),
        .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy, mreq, adr, mw, irw, pcw, rw, flt;
        logic [1:0] rs, sa, sb;
        logic [2:0] alu, imm;
    } rec_t;

    rec_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] cur_imm;

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic bit br_legal(input logic [2:0] f3);
`ifdef MULTICYCLE_CTRL_FULL_BRANCH_EN
        return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5;
`else
        return f3 == 3'd0;
`endif
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic [1:0] fl);
        case (f3)
            3'd1:    return !fl[0];
            3'd4:    return fl[1];
            3'd5:    return !fl[1];
            default: return fl[0];
        endcase
    endfunction

    function automatic rec_t base(input logic [3:0] st);
        rec_t r;
        r     = '0;
        r.st  = st;
        r.rdy = 1'($urandom);
        r.flt = (st == ST_HALT);
        r.imm = (st == ST_HALT) ? 3'b000 : cur_imm;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // w not-ready cycles, then completion; more than TO waits means timeout
    task automatic mem_phase(input rec_t b, input int w, output bit h);
        rec_t r;
        for (int i = 0; i < w && i <= TO; i++) begin
            r     = b;
            r.rdy = 1'b0;
            q.push_back(r);
        end
        h = (w > TO);
        if (!h) begin
            r     = b;
            r.rdy = 1'b1;
            if (b.st == ST_FETCH) begin
                r.irw = 1'b1;
                r.pcw = 1'b1;
            end
            q.push_back(r);
        end
    endtask

    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic [1:0] fl, input int wf, input int wm,
                         output bit h);
        rec_t r;
        h = 1'b0;
        q.delete();
        op = o; funct3 = f3; funct7b5 = f7; Flags = fl;
        cur_imm = imm_of(o);
        r = base(ST_FETCH); r.mreq = 1'b1; r.sb = 2'd2; r.rs = 2'd2;
        mem_phase(r, wf, h);
        if (!h) begin
            r = base(ST_DECODE); r.sa = 2'd1; r.sb = 2'd1;
            q.push_back(r);
            case (o)
                7'b0000011, 7'b0100011: begin
                    r = base(ST_MEMADR); r.sa = 2'd2; r.sb = 2'd1;
                    q.push_back(r);
                    if (o[5]) begin
                        r = base(ST_MEMWRITE); r.mreq = 1'b1; r.adr = 1'b1; r.mw = 1'b1;
                        mem_phase(r, wm, h);
                    end else begin
                        r = base(ST_MEMREAD); r.mreq = 1'b1; r.adr = 1'b1;
                        mem_phase(r, wm, h);
                        if (!h) begin
                            r = base(ST_MEMWB); r.rs = 2'd1; r.rw = 1'b1;
                            q.push_back(r);
                        end
                    end
                end
                7'b0110011, 7'b0010011: begin
                    r = base(o[5] ? ST_EXECR : ST_EXECI);
                    r.sa = 2'd2;
                    r.sb = o[5] ? 2'd0 : 2'd1;
                    case (f3)
                        3'd0:    r.alu = (o[5] && f7) ? 3'b001 : 3'b000;
                        3'd2:    r.alu = 3'b101;
                        3'd6:    r.alu = 3'b011;
                        3'd7:    r.alu = 3'b010;
                        default: h = 1'b1;
                    endcase
                    q.push_back(r);
                    if (!h) begin
                        r = base(ST_ALUWB); r.rw = 1'b1;
                        q.push_back(r);
                    end
                end
                7'b1100011: begin
                    if (br_legal(f3)) begin
                        r = base(ST_BRANCH); r.sa = 2'd2; r.alu = 3'b001;
                        r.pcw = taken(f3, fl);
                        q.push_back(r);
                    end else h = 1'b1;
                end
                7'b1101111: begin
                    r = base(ST_JAL); r.sa = 2'd1; r.sb = 2'd2; r.pcw = 1'b1;
                    q.push_back(r);
                    r = base(ST_ALUWB); r.rw = 1'b1;
                    q.push_back(r);
                end
                default: h = 1'b1;
            endcase
        end
        if (h) repeat (3) q.push_back(base(ST_HALT));
    endtask

    task automatic play(input string tag, input int n);
        rec_t obs;
        for (int i = 0; i < q.size() && i < n; i++) begin
            MemReady = q[i].rdy;
            @(negedge clk);
            obs = {State, MemReady, MemReq, AdrSrc, MemWrite, IRWrite, PCWrite,
                   RegWrite, Fault, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc};
            checks++;
            assert (obs === q[i]) else begin
                errors++;
                $error("FAIL %s cyc %0d obs=%h exp=%h", tag, i, obs, q[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        rec_t r;
        reset = 1'b0;
        #1;
        chk({tag, "_async"}, {State, MemReq, MemWrite, IRWrite, PCWrite, RegWrite, Fault},
            {ST_FETCH, 6'b0});
        repeat (3) begin
            @(negedge clk);
            chk({tag, "_hold"}, {State, MemReq, MemWrite, IRWrite, PCWrite, RegWrite,
                AdrSrc, Fault, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc},
                {ST_FETCH, 7'b0, 9'b0});
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        r = '0; r.st = ST_FETCH; r.rdy = 1'($urandom);
        q.push_back(r);
        play({tag, "_idle"}, 1);
    endtask

    task automatic run(input string tag, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic [1:0] fl, input int wf, input int wm);
        bit h;
        build(o, f3, f7, fl, wf, wm, h);
        play(tag, 1000);
        if (h) do_reset({tag, "_rst"});
    endtask

    initial begin
        logic [6:0] ops [7];
        bit         h;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b0000000};
        reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0;
        Flags = '0; MemReady = 1'b1;
        #2;
        do_reset("reset");

        run("rsub",     7'b0110011, 3'd0, 1'b1, 2'b00, 0, 0);
        run("addi_b30", 7'b0010011, 3'd0, 1'b1, 2'b00, 1, 0);
        run("r_or",     7'b0110011, 3'd6, 1'b0, 2'b00, 2, 0);
        run("load_w3",  7'b0000011, 3'd2, 1'b0, 2'b00, 0, 3);
        run("store_w2", 7'b0100011, 3'd2, 1'b0, 2'b00, 0, 2);
        run("beq_t",    7'b1100011, 3'd0, 1'b0, 2'b01, 0, 0);
        run("beq_nt",   7'b1100011, 3'd0, 1'b0, 2'b00, 0, 0);
        run("bne",      7'b1100011, 3'd1, 1'b0, 2'b00, 0, 0);
        run("blt",      7'b1100011, 3'd4, 1'b0, 2'b10, 0, 0);
        run("jal",      7'b1101111, 3'd0, 1'b0, 2'b00, 1, 0);
        run("r_badf3",  7'b0110011, 3'd1, 1'b0, 2'b00, 0, 0);
        run("fetch_to", 7'b0110011, 3'd0, 1'b0, 2'b00, 10, 0);
        run("edge_ok",  7'b0000011, 3'd2, 1'b0, 2'b00, TO, TO);
        run("rd_to",    7'b0000011, 3'd2, 1'b0, 2'b00, 0, TO + 1);
        run("illegal",  7'b1111111, 3'd0, 1'b0, 2'b00, 0, 0);

        build(7'b0100011, 3'd2, 1'b0, 2'b00, 0, 3, h);
        play("st_abort", 5);
        do_reset("st_abort_rst");

        repeat (60) begin
            run("rand", ops[$urandom % 7], 3'($urandom), 1'($urandom),
                2'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
